// File: rtl/digit_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// digit_rr_arbiter_pkg
// Shared definitions for the round-robin HEX0 display arbiter:
//   - state_t        : arbiter FSM encoding (IDLE, HOLD)
//   - NREQ, LAST_IDX : number of requesters and highest legal index
//   - SEG_0..SEG_9   : active-low {g,f,e,d,c,b,a} patterns for digits 0-9
//   - SEG_BLANK      : all segments off
//   - wrap_idx()     : folds a 0..18 sum back into the 0..9 index range
// ---------------------------------------------------------------------------
package digit_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int         NREQ     = 10;
    localparam logic [3:0] LAST_IDX = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Both operands of every caller are at most 9, so a single conditional
    // subtraction is enough to implement "mod 10".
    function automatic logic [3:0] wrap_idx(input logic [4:0] sum);
        logic [4:0] folded;
        folded = sum;
        if (sum > {1'b0, LAST_IDX}) begin
            folded = sum - 5'd10;
        end
        return folded[3:0];
    endfunction

endpackage

// File: rtl/digit_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// digit_rr_arbiter_if
// Bundles the request/grant/display signals of the arbiter.
//   req     : request vector, one bit per switch
//   grant   : one-hot grant, zero when idle
//   gnt_idx : binary index of the holder, keeps last value when idle
//   valid   : a grant is active
//   hex     : active-low seven-segment pattern for HEX0
// Modports:
//   master : the environment (drives req, observes the rest)
//   slave  : the arbiter (reads req, drives the rest)
// ---------------------------------------------------------------------------
interface digit_rr_arbiter_if;
    import digit_rr_arbiter_pkg::*;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [3:0]      gnt_idx;
    logic            valid;
    logic [6:0]      hex;

    modport master (
        output req,
        input  grant,
        input  gnt_idx,
        input  valid,
        input  hex
    );

    modport slave (
        input  req,
        output grant,
        output gnt_idx,
        output valid,
        output hex
    );

endinterface

// File: rtl/digit_rr_arbiter_hex_digit_decoder.sv
// ---------------------------------------------------------------------------
// hex_digit_decoder
// Combinational 4-bit to seven-segment decoder with enable.
//   digit_i : binary digit to show (0-9 decode, anything else blanks)
//   en_i    : 0 forces the blank pattern
//   seg_o   : active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_digit_decoder
    import digit_rr_arbiter_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       en_i,
    output logic [6:0] seg_o
);

    // Straight lookup; codes 10-15 and a disabled display both blank the digit.
    always_comb begin
        seg_o = SEG_BLANK;
        if (en_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/digit_rr_arbiter.sv
// ---------------------------------------------------------------------------
// digit_rr_arbiter
// Time-shares the HEX0 digit among ten requesters in round-robin order.
// Each winner holds the display for DWELL cycles unless it drops its own
// request first; the digit shows the holder's index.
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : digit_rr_arbiter_if.slave (req in; grant, gnt_idx, valid, hex out)
// Parameters:
//   DWELL : grant hold time in cycles (2 .. 2^26-1)
//   CW    : dwell counter width, 2^CW must exceed DWELL
// ---------------------------------------------------------------------------
module digit_rr_arbiter
    import digit_rr_arbiter_pkg::*;
#(
    parameter int DWELL = 50_000_000,
    parameter int CW    = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_rr_arbiter_if.slave    bus
);

    localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
    localparam logic [NREQ-1:0] ONE_HOT_0  = {{(NREQ-1){1'b0}}, 1'b1};

    state_t          state_q,   state_d;
    logic [3:0]      ptr_q,     ptr_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [NREQ-1:0] grant_q,   grant_d;
    logic [3:0]      gnt_idx_q, gnt_idx_d;
    logic            valid_q,   valid_d;

    logic            found;
    logic [3:0]      winner;
    logic [3:0]      cand;
    logic            holder_active;
    logic            dwell_done;

    // Rotating priority search: visit ptr, ptr+1, ... wrapping past 9, and
    // keep the first requester seen. The search always runs so that a
    // hand-over can happen in the same cycle the current grant ends.
    always_comb begin
        found  = 1'b0;
        winner = 4'd0;
        cand   = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_idx({1'b0, ptr_q} + 5'(k));
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // The holder is still interested if its own request bit is set; masking
    // with the one-hot grant avoids indexing req with gnt_idx.
    assign holder_active = |(bus.req & grant_q);
    assign dwell_done    = (cnt_q == DWELL_LAST);

    // Next-state logic. An early release takes precedence over the terminal
    // count, but both end up re-arbitrating from ptr, so they share one path:
    // either hand the digit to the next requester with no gap, or go idle.
    // gnt_idx is left alone on the way to IDLE so it keeps its last value.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        gnt_idx_d = gnt_idx_q;
        valid_d   = valid_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = HOLD;
                    grant_d   = ONE_HOT_0 << winner;
                    gnt_idx_d = winner;
                    valid_d   = 1'b1;
                    cnt_d     = '0;
                    ptr_d     = wrap_idx({1'b0, winner} + 5'd1);
                end
            end

            HOLD: begin
                if (!holder_active || dwell_done) begin
                    if (found) begin
                        state_d   = HOLD;
                        grant_d   = ONE_HOT_0 << winner;
                        gnt_idx_d = winner;
                        valid_d   = 1'b1;
                        cnt_d     = '0;
                        ptr_d     = wrap_idx({1'b0, winner} + 5'd1);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // All FSM state and the registered outputs live in this one register
    // bank; reset is asynchronous so the display blanks the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 4'd0;
            cnt_q     <= '0;
            grant_q   <= '0;
            gnt_idx_q <= 4'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            gnt_idx_q <= gnt_idx_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.valid   = valid_q;

    // The segment pattern is decoded from registered values only, so it
    // changes on the same edge as the other outputs.
    hex_digit_decoder u_hex_digit_decoder (
        .digit_i (gnt_idx_q),
        .en_i    (valid_q),
        .seg_o   (bus.hex)
    );

endmodule

// File: doc/digit_rr_arbiter.md
# digit_rr_arbiter

Round-robin arbiter that shares the single HEX0 seven-segment digit among ten requesters (one per switch, SW[9:0]). Each active requester is granted the display for a fixed dwell time, during which its index (0-9) is shown on HEX0. Idle requesters are skipped. The block replaces the static one-hot-to-BCD path from the switches to HEX0 with a sequenced, time-shared display controller.

## Interface
- DWELL, 50_000_000: grant hold time in clock cycles (1 s at 50 MHz); legal range 2..2^26-1.
- CW, 26: dwell counter width; must satisfy 2^CW > DWELL.

- clk  input  1  system clock (CLOCK_50 on the board).
- rst  input  1  asynchronous, active-high reset.
- req  input  10  request vector; req[i]=1 means requester i wants the display. Asynchronous board inputs are synchronized externally.
- grant  output  10  one-hot grant. All-zero when idle.
- gnt_idx  output  4  binary index of the granted requester (0-9). Holds its last value when idle.
- valid  output  1  1 while a grant is active.
- hex  output  7  active-low segments {g,f,e,d,c,b,a} showing gnt_idx. All-ones (blank) when valid=0.

## Operation
- States:
  - IDLE: no grant.
  - HOLD: grant active, dwell counter running.
- Pointer ptr[3:0] (0-9) gives the search start. The arbiter picks the first i with req[i]=1, scanning ptr, ptr+1, …, 9, 0, … ptr-1 (mod 10).
- IDLE -> HOLD: when req≠0, grant the selected requester, load cnt=0, and set ptr=(winner+1) mod 10.
- While in HOLD, cnt increments every cycle.
- Leaving HOLD, checked in this priority order:
  - Early release: if req[gnt_idx]=0, end the grant. Re-arbitrate from ptr in the same cycle. If req=0, go to IDLE.
  - Terminal count: if cnt=DWELL-1, re-arbitrate from ptr. A sole active requester is re-granted, cnt reloads to 0, and valid stays 1 with no gap. If req=0, go to IDLE.
  - Otherwise, stay in HOLD and keep the grant.
- Requests that change mid-dwell do not pre-empt the current grant. Only the current holder's own deassertion ends it early.
- ptr wraps 9->0. Multiple simultaneous requests are resolved only by ptr order, with no fixed priority.
- Segment decoding uses digits 0-9 as the existing display convention: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other code gives 1111111.

## Timing
- Reset values:
  - grant=0, gnt_idx=0, valid=0, hex=1111111.
  - state=IDLE, ptr=0, cnt=0.
- grant, gnt_idx, valid and the state are registered. hex is decoded combinationally from the registered gnt_idx/valid, so all four outputs change on the same clock edge.
- Latency:
  - A request sampled at edge N in IDLE gives valid=1 after edge N.
  - Release is visible one edge after the holder's req falls.
- Each full-dwell grant lasts exactly DWELL cycles.
- Hand-over between requesters is gapless. IDLE is entered only when req=0 at the decision edge.
- rst asserted at any time, including mid-HOLD, forces the reset values immediately, without waiting for a clock. The first arbitration after release starts from ptr=0.

## Structure
- Shared package holds:
  - the state encoding (IDLE, HOLD);
  - the constant NREQ=10;
  - the 10-entry segment pattern constants and the blank pattern.
- One sub-module: hex_digit_decoder. It is a combinational 4-bit -> 7-segment decoder with an enable; enable=0 drives blank.
- The arbiter top contains the FSM, ptr, the dwell counter and the rotating priority search, implemented as a loop over NREQ.

## Test plan
Run with DWELL=4.
- Reset mid-HOLD: req=0000100000, assert rst during cycle 2 of the dwell -> outputs return to reset values without a clock edge. After release, req=0000100000 gives gnt_idx=5 one cycle later.
- Single requester: req=0000001000 -> gnt_idx=3, hex=0110000, valid held continuously. grant is re-issued to 3 every 4 cycles with no gap.
- Rotation with wrap: req=1000000011 -> grant order 0,1,9,0,1,9, each for exactly 4 cycles. hex goes 1000000, 1111001, 0010000.
- Early release: grant on 2, drop req[2] at dwell cycle 1 while req[7]=1 -> gnt_idx=7 on the next edge. If req=0 instead, valid=0 and hex=1111111.
- No pre-emption: while 4 is held, assert req[0] -> 4 is kept for the full 4 cycles, then 0 is granted (ptr=5, wrap).
- Idle: req=0 from reset for 20 cycles -> valid=0, grant=0, hex=1111111 throughout.
